// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction memory boot loader.
//
// Contents:
//   BYTES_PER_WORD - program bytes that make up one instruction word
//   INSTR_WIDTH    - width of an instruction word in bits
//   loader_state_e - loader FSM states (IDLE, LOAD, WRITE, DONE)

package instr_mem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int INSTR_WIDTH    = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } loader_state_e;

endpackage

// File: rtl/instr_mem_loader_byte_assembler.sv
// Byte-to-word assembler for the boot loader.
// Shifts accepted bytes in most-significant-first and flags the byte
// that completes a word.
//
// Ports:
//   clk             - system clock, rising edge
//   reset           - synchronous active-high reset
//   clear_i         - discard any partial word and restart the byte count
//   accept_i        - byte_i is taken on this edge
//   byte_i          - incoming program byte
//   word_o          - assembled word register
//   word_complete_o - the byte being accepted now is the last of a word

module instr_mem_loader_byte_assembler
    import instr_mem_loader_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear_i,
    input  logic                   accept_i,
    input  logic [7:0]             byte_i,
    output logic [INSTR_WIDTH-1:0] word_o,
    output logic                   word_complete_o
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic [1:0]             count_q, count_d;
    logic [INSTR_WIDTH-1:0] word_q, word_d;

    // Next-state for the shift register and byte counter. Clear has
    // priority so a new session never inherits bytes from an old one.
    always_comb begin
        count_d = count_q;
        word_d  = word_q;
        if (clear_i) begin
            count_d = '0;
            word_d  = '0;
        end else if (accept_i) begin
            word_d  = {word_q[INSTR_WIDTH-9:0], byte_i};
            count_d = count_q + 2'd1;
        end
    end

    // Register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            word_q  <= '0;
        end else begin
            count_q <= count_d;
            word_q  <= word_d;
        end
    end

    assign word_o          = word_q;
    assign word_complete_o = accept_i && (count_q == LAST_BYTE);

endmodule

// File: rtl/instr_mem_loader.sv
// Boot loader for the instruction memory. Receives a byte stream,
// assembles 32-bit words (MSB first) and writes them to ascending
// addresses while holding the processor in stall.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous active-high reset
//   start      - pulse; begins a load session from IDLE or DONE
//   byte_valid - byte_data holds a valid byte
//   byte_data  - incoming program byte
//   byte_ready - loader accepts a byte this cycle
//   wr_en      - instruction memory write strobe, one cycle per word
//   wr_addr    - write address
//   wr_data    - instruction word to write
//   cpu_hold   - stall request to the processor while loading
//   done       - load complete, held until next start or reset
//   checksum   - modulo-2^32 sum of words written this session

module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int WORD_COUNT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   byte_valid,
    input  logic [7:0]             byte_data,
    output logic                   byte_ready,
    output logic                   wr_en,
    output logic [ADDR_WIDTH-1:0]  wr_addr,
    output logic [INSTR_WIDTH-1:0] wr_data,
    output logic                   cpu_hold,
    output logic                   done,
    output logic [INSTR_WIDTH-1:0] checksum
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_COUNT - 1);

    loader_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
    logic [INSTR_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [INSTR_WIDTH-1:0] checksum_q, checksum_d;

    logic                   asm_clear;
    logic                   asm_accept;
    logic [INSTR_WIDTH-1:0] asm_word;
    logic                   asm_complete;

    // Bytes are only taken while loading; byte_ready is exactly this state.
    assign asm_accept = byte_valid && (state_q == LOAD);

    instr_mem_loader_byte_assembler u_assembler (
        .clk             (clk),
        .reset           (reset),
        .clear_i         (asm_clear),
        .accept_i        (asm_accept),
        .byte_i          (byte_data),
        .word_o          (asm_word),
        .word_complete_o (asm_complete)
    );

    // Next-state logic for the FSM, address counter, held write data
    // and checksum. The WRITE state lasts exactly one cycle; the address
    // stops at the last word rather than wrapping.
    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        checksum_d = checksum_q;
        asm_clear  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = LOAD;
                    wr_addr_d  = '0;
                    checksum_d = '0;
                    asm_clear  = 1'b1;
                end
            end
            LOAD: begin
                if (asm_complete) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                wr_data_d  = asm_word;
                checksum_d = checksum_q + asm_word;
                if (wr_addr_q == LAST_ADDR) begin
                    state_d = DONE;
                end else begin
                    wr_addr_d = wr_addr_q + 1'b1;
                    state_d   = LOAD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            checksum_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            checksum_q <= checksum_d;
        end
    end

    // During WRITE the freshly assembled word is presented directly;
    // afterwards the captured copy keeps wr_data stable while the
    // assembler shifts in the next word.
    assign wr_data    = (state_q == WRITE) ? asm_word : wr_data_q;
    assign wr_addr    = wr_addr_q;
    assign wr_en      = (state_q == WRITE);
    assign byte_ready = (state_q == LOAD);
    assign cpu_hold   = (state_q == LOAD) || (state_q == WRITE);
    assign done       = (state_q == DONE);
    assign checksum   = checksum_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed testbench for instr_mem_loader (ADDR_WIDTH=4, WORD_COUNT=16).
// Inputs change on the falling edge; outputs are sampled on the falling
// edge, half a cycle away from the active rising edge.

module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic [31:0] checksum;

    int assertCount = 0;
    int failCount   = 0;
    int holdDrops   = 0;
    logic holdWatch = 1'b0;

    logic [3:0]  wrAddrQ[$];
    logic [31:0] wrDataQ[$];

    instr_mem_loader #(
        .ADDR_WIDTH (4),
        .WORD_COUNT (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .checksum   (checksum)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Record every write strobe and watch for cpu_hold dropping while a
    // session is supposed to be in progress.
    always @(negedge clk) begin
        if (wr_en) begin
            wrAddrQ.push_back(wr_addr);
            wrDataQ.push_back(wr_data);
        end
        if (holdWatch && !cpu_hold) begin
            holdDrops++;
        end
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Present one byte, wait (bounded) until the loader is ready, let the
    // next rising edge take it, then idle the source for 'gap' cycles.
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        int tries = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && tries < 50) begin
            @(negedge clk);
            tries++;
        end
        checkOutput("byteReady", 32'(byte_ready), 32'd1);
        @(negedge clk);
        byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // Send one word MSB first; on return (with gap 0) the bench sits in
    // the WRITE cycle for that word.
    task automatic sendWord(input logic [31:0] w, input int gap);
        logic [31:0] tmp;
        tmp = w;
        for (int k = 3; k >= 0; k--) begin
            applyStimulus(tmp[k*8 +: 8], gap);
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic waitDone();
        int n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("doneSeen", 32'(done), 32'd1);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;

        // Reset asserted together with start: reset must win.
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        checkOutput("rstWr_en", 32'(wr_en), 32'd0);
        checkOutput("rstWr_addr", 32'(wr_addr), 32'd0);
        checkOutput("rstWr_data", wr_data, 32'd0);
        checkOutput("rstByteReady", 32'(byte_ready), 32'd0);
        checkOutput("rstCpuHold", 32'(cpu_hold), 32'd0);
        checkOutput("rstDone", 32'(done), 32'd0);
        checkOutput("rstChecksum", checksum, 32'd0);

        // Basic word: four back-to-back bytes produce one write at address 0.
        pulseStart();
        checkOutput("loadByteReady", 32'(byte_ready), 32'd1);
        checkOutput("loadCpuHold", 32'(cpu_hold), 32'd1);
        sendWord(32'h20080005, 0);
        checkOutput("basicWr_en", 32'(wr_en), 32'd1);
        checkOutput("basicWr_addr", 32'(wr_addr), 32'd0);
        checkOutput("basicWr_data", wr_data, 32'h20080005);
        checkOutput("basicSumBefore", checksum, 32'd0);
        @(negedge clk);
        checkOutput("basicWr_enLow", 32'(wr_en), 32'd0);
        checkOutput("basicSum", checksum, 32'h20080005);
        checkOutput("basicDataHeld", wr_data, 32'h20080005);
        checkOutput("basicAddrNext", 32'(wr_addr), 32'd1);

        // Reset mid-word: partial word is dropped, no write issued.
        pulseReset();
        wrAddrQ.delete();
        wrDataQ.delete();
        pulseStart();
        applyStimulus(8'hAA, 0);
        applyStimulus(8'hBB, 0);
        pulseReset();
        checkOutput("midRstCpuHold", 32'(cpu_hold), 32'd0);
        checkOutput("midRstByteReady", 32'(byte_ready), 32'd0);
        checkOutput("midRstWr_en", 32'(wr_en), 32'd0);

        // Bytes offered in IDLE are refused.
        byte_valid = 1'b1;
        byte_data  = 8'hEE;
        repeat (3) @(negedge clk);
        checkOutput("idleByteReady", 32'(byte_ready), 32'd0);
        checkOutput("midRstNoWrite", 32'(wrAddrQ.size()), 32'd0);
        byte_valid = 1'b0;

        // New session's first word must carry no stale bytes.
        pulseStart();
        sendWord(32'h11223344, 0);
        checkOutput("cleanWr_addr", 32'(wr_addr), 32'd0);
        checkOutput("cleanWr_data", wr_data, 32'h11223344);

        // Full load: words 0..15, first four with a stalled source, the
        // rest back-to-back, with start pulses during WRITE and LOAD.
        pulseReset();
        wrAddrQ.delete();
        wrDataQ.delete();
        pulseStart();
        holdWatch = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 6) begin
                pulseStart();
                pulseStart();
            end
            sendWord(32'(i), (i < 4) ? 3 : 0);
        end
        holdWatch = 1'b0;
        waitDone();
        @(negedge clk);
        checkOutput("fullCpuHold", 32'(cpu_hold), 32'd0);
        checkOutput("fullDone", 32'(done), 32'd1);
        checkOutput("fullChecksum", checksum, 32'h00000078);
        checkOutput("fullLastAddr", 32'(wr_addr), 32'd15);
        checkOutput("holdDrops", 32'(holdDrops), 32'd0);
        checkOutput("fullWriteCount", 32'(wrAddrQ.size()), 32'd16);
        for (int i = 0; i < 16 && i < wrAddrQ.size(); i++) begin
            checkOutput($sformatf("fullAddr%0d", i), 32'(wrAddrQ[i]), 32'(i));
            checkOutput($sformatf("fullData%0d", i), wrDataQ[i], 32'(i));
        end

        // Bytes offered in DONE are refused and no 17th write appears.
        byte_valid = 1'b1;
        byte_data  = 8'h55;
        repeat (3) @(negedge clk);
        checkOutput("doneByteReady", 32'(byte_ready), 32'd0);
        checkOutput("noExtraWrite", 32'(wrAddrQ.size()), 32'd16);
        byte_valid = 1'b0;

        // Restart from DONE: done falls on the start edge, address and
        // checksum restart from zero.
        pulseStart();
        checkOutput("restartDone", 32'(done), 32'd0);
        checkOutput("restartAddr", 32'(wr_addr), 32'd0);
        checkOutput("restartSum", checksum, 32'd0);
        checkOutput("restartCpuHold", 32'(cpu_hold), 32'd1);
        sendWord(32'hCAFEF00D, 0);
        checkOutput("restartWr_addr", 32'(wr_addr), 32'd0);
        checkOutput("restartWr_data", wr_data, 32'hCAFEF00D);
        @(negedge clk);
        checkOutput("restartChecksum", checksum, 32'hCAFEF00D);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Write-side companion to the instruction memory: a boot loader that receives a byte stream and writes 32-bit instruction words into instruction memory at ascending addresses.
- Holds the processor in stall while loading, then releases it.
- Sits between a byte source (UART receiver, test harness) and the instruction memory write port.

Parameters:
- ADDR_WIDTH, 4, instruction memory address width (16 words).
- WORD_COUNT, 16, words loaded per session; legal range 1..2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a load session when idle or done.
- byte_valid  input  1  byte_data holds a valid byte.
- byte_data  input  8  incoming program byte, most significant byte of each word first.
- byte_ready  output  1  loader accepts a byte this cycle.
- wr_en  output  1  instruction memory write strobe, one cycle per word.
- wr_addr  output  ADDR_WIDTH  write address.
- wr_data  output  32  instruction word to write.
- cpu_hold  output  1  stall request to the processor/PC while loading.
- done  output  1  load complete; level, held until the next start or reset.
- checksum  output  32  modulo-2^32 sum of all words written this session.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset. All state is registered.
- Reset values: state=IDLE, wr_en=0, wr_addr=0, wr_data=0, byte_ready=0, cpu_hold=0, done=0, checksum=0. The byte counter and assembly register are cleared.
- States: IDLE, LOAD, WRITE, DONE.
- IDLE:
  - byte_ready=0, cpu_hold=0.
  - start=1 -> LOAD; clear wr_addr, byte counter and checksum.
- LOAD:
  - byte_ready=1, cpu_hold=1.
  - A byte is accepted on a cycle where byte_valid and byte_ready are both 1.
  - On accept: word <= {word[23:0], byte_data}; byte counter increments mod 4.
  - The 4th accepted byte transitions to WRITE on the next edge.
  - byte_valid=0 stalls indefinitely; there is no timeout.
- WRITE (exactly one cycle):
  - wr_en=1, wr_data=assembled word, wr_addr=current address, byte_ready=0, cpu_hold=1.
  - checksum <= checksum + word, visible the cycle after WRITE.
  - If wr_addr==WORD_COUNT-1 -> DONE; else wr_addr++ and -> LOAD.
- Latency and throughput:
  - The 4th byte is accepted at edge N; wr_en is high during cycle N to N+1.
  - Minimum throughput is 5 cycles per word.
- DONE:
  - done=1, cpu_hold=0, byte_ready=0.
  - wr_addr and checksum hold their final values.
  - start -> LOAD with done cleared on the same edge.
- Output stability:
  - wr_en is low in every state except WRITE.
  - wr_data and wr_addr keep their last values outside WRITE.
- Boundary conditions:
  - start during LOAD or WRITE is ignored.
  - Bytes presented outside LOAD are not accepted (byte_ready=0).
  - wr_addr never wraps within a session; WORD_COUNT=2**ADDR_WIDTH ends at address all-ones.
  - WORD_COUNT=1: one WRITE, then DONE.
  - reset mid-LOAD (partial word): partial word discarded, no write issued, IDLE next cycle, cpu_hold=0.
  - reset asserted together with start: reset wins.
  - byte_valid=1 in the same cycle as the LOAD->WRITE transition: that byte is not accepted and must be held by the source.

Decomposition:
- Shared package:
  - loader state enum (IDLE, LOAD, WRITE, DONE).
  - BYTES_PER_WORD=4.
  - INSTR_WIDTH=32.
- Sub-module byte_assembler:
  - 2-bit byte counter plus 32-bit shift register.
  - Inputs: clear, accept, byte.
  - Outputs: word, word_complete.
  - The top level contains the FSM, address counter and checksum.

Test Plan:
- Basic word: reset, start, bytes 0x20,0x08,0x00,0x05 back-to-back -> single wr_en with wr_addr=0, wr_data=0x20080005 one cycle after the 4th byte accepted; checksum=0x20080005.
- Full load: WORD_COUNT=16, words 0x00000000..0x0000000F streamed -> 16 wr_en pulses, addresses 0..15 in order; done=1, cpu_hold=0; checksum=0x00000078; no 17th write.
- Stalled source: byte_valid low 3 cycles between each byte -> word assembled unchanged, wr_en still exactly one pulse per word, cpu_hold stays 1 throughout.
- Reset mid-word: after 2 bytes (0xAA,0xBB), assert reset one cycle -> no wr_en; state IDLE; next session's first word 0x11223344 is written as 0x11223344 with no stale bytes.
- Ignored events: start pulsed during LOAD, and byte_valid=1 while in IDLE and in WRITE -> no restart, no extra bytes accepted, address sequence unaffected.
- Restart from DONE: after a completed load, start -> done falls on the same edge, wr_addr restarts at 0, checksum restarts from 0.
